// File: rtl/commit_trace_if.sv
// commit_trace_if: retirement-event input and trace-entry output bundle of commit_trace_buffer
interface commit_trace_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int INST_W = 16,
  parameter int REG_W = 3,
  parameter int CNT_W = 32
);
  logic cmt_valid;
  logic [ADDR_W-1:0] cmt_pc;
  logic [INST_W-1:0] cmt_inst;
  logic cmt_reg_wr;
  logic [REG_W-1:0] cmt_reg;
  logic [DATA_W-1:0] cmt_reg_data;
  logic cmt_mem_rd;
  logic cmt_mem_wr;
  logic [ADDR_W-1:0] cmt_mem_addr;
  logic [DATA_W-1:0] cmt_mem_data;
  logic cmt_halt;
  logic out_valid;
  logic out_ready;
  logic [2:0] out_kind;
  logic [CNT_W-1:0] out_inum;
  logic [ADDR_W-1:0] out_pc;
  logic [INST_W-1:0] out_inst;
  logic [REG_W-1:0] out_reg;
  logic [DATA_W-1:0] out_reg_data;
  logic [ADDR_W-1:0] out_mem_addr;
  logic [DATA_W-1:0] out_mem_data;
  modport master (
    output cmt_valid, cmt_pc, cmt_inst, cmt_reg_wr, cmt_reg, cmt_reg_data, cmt_mem_rd, cmt_mem_wr,
           cmt_mem_addr, cmt_mem_data, cmt_halt, out_ready,
    input  out_valid, out_kind, out_inum, out_pc, out_inst, out_reg, out_reg_data, out_mem_addr, out_mem_data
  );
  modport slave (
    input  cmt_valid, cmt_pc, cmt_inst, cmt_reg_wr, cmt_reg, cmt_reg_data, cmt_mem_rd, cmt_mem_wr,
           cmt_mem_addr, cmt_mem_data, cmt_halt, out_ready,
    output out_valid, out_kind, out_inum, out_pc, out_inst, out_reg, out_reg_data, out_mem_addr, out_mem_data
  );
endinterface

// File: rtl/commit_trace_buffer.sv
// commit_trace_buffer: classifies, numbers and queues retirement events for a trace consumer
module commit_trace_buffer #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int INST_W = 16,
  parameter int REG_W = 3,
  parameter int CNT_W = 32,
  parameter int DEPTH = 16,
  parameter bit TRACE_NOP = 1'b1
) (
  input  logic clk,
  input  logic rst,
  commit_trace_if.slave bus,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] inst_count,
  output logic [CNT_W-1:0] drop_count,
  output logic overflow,
  output logic halted,
  output logic done
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int E_W = 3 + CNT_W + 2 * ADDR_W + INST_W + REG_W + 2 * DATA_W;
  typedef enum logic [1:0] {RUN, HALTED, DONE} state_t;
  state_t state, nextState;
  logic [E_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wrPtr, rdPtr, wrAddr;
  logic [PTR_W:0] count;
  logic [2:0] kind;
  logic accept, push, pop, full, drop, enq, write, notEmpty;
  assign kind = (bus.cmt_reg_wr && bus.cmt_mem_wr) ? 3'd4 :
                (bus.cmt_reg_wr && bus.cmt_mem_rd) ? 3'd2 :
                bus.cmt_reg_wr ? 3'd1 :
                bus.cmt_halt ? 3'd5 :
                bus.cmt_mem_wr ? 3'd3 : 3'd0;
  assign accept = bus.cmt_valid && state == RUN;
  assign push = accept && (TRACE_NOP || kind != 3'd0);
  assign notEmpty = count != '0;
  assign pop = notEmpty && bus.out_ready;
  assign full = count == (PTR_W+1)'(DEPTH);
  assign drop = push && full && !pop;
  assign enq = push && !drop;
  // a HALT that finds the FIFO full replaces the newest entry so the stop marker always reaches the dumper
  assign write = enq || (drop && bus.cmt_halt);
  assign wrAddr = drop ? wrPtr - PTR_W'(1) : wrPtr;
  assign bus.out_valid = notEmpty;
  assign {bus.out_kind, bus.out_inum, bus.out_pc, bus.out_inst, bus.out_reg, bus.out_reg_data,
          bus.out_mem_addr, bus.out_mem_data} = mem[rdPtr];
  always_ff @(posedge clk)
    if (write) mem[wrAddr] <= {kind, inst_count, bus.cmt_pc, bus.cmt_inst, bus.cmt_reg, bus.cmt_reg_data,
                               bus.cmt_mem_addr, bus.cmt_mem_data};
  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
      cycle_count <= '0;
      inst_count <= '0;
      drop_count <= '0;
      overflow <= 1'b0;
    end else begin
      if (enq) wrPtr <= wrPtr + PTR_W'(1);
      if (pop) rdPtr <= rdPtr + PTR_W'(1);
      count <= count + (PTR_W+1)'(enq) - (PTR_W+1)'(pop);
      if (state == RUN) cycle_count <= cycle_count + CNT_W'(1);
      if (accept) inst_count <= inst_count + CNT_W'(1);
      if (drop) overflow <= 1'b1;
      if (drop && !(&drop_count)) drop_count <= drop_count + CNT_W'(1);
    end
  end
  always_ff @(posedge clk) state <= rst ? RUN : nextState;
  always_comb
    nextState = state == RUN ? ((accept && bus.cmt_halt) ? HALTED : RUN) :
                state == HALTED ? ((!notEmpty && !push) ? DONE : HALTED) : DONE;
  always_comb begin
    halted = state != RUN;
    done = state == DONE;
  end
endmodule

// File: tb/tb_commit_trace_buffer.sv
// tb_commit_trace_buffer: directed commits with a scoreboard queue checked by an output monitor
module tb_commit_trace_buffer;
  typedef struct packed {
    logic [2:0] kind;
    logic [31:0] inum;
    logic [15:0] pc, inst;
    logic [2:0] rg;
    logic [15:0] rd, ma, md;
  } ent_t;
  logic clk = 1'b0, rst = 1'b1;
  logic [31:0] cycle_count, inst_count, drop_count;
  logic overflow, halted, done;
  int errors = 0, checks = 0;
  ent_t expq[$];
  ent_t act, exq;
  commit_trace_if bus();
  commit_trace_buffer #(.DEPTH(4), .TRACE_NOP(1'b0)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .cycle_count(cycle_count), .inst_count(inst_count), .drop_count(drop_count),
    .overflow(overflow), .halted(halted), .done(done)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask
  always @(negedge clk)
    if (!rst && bus.out_valid && bus.out_ready) begin
      act = {bus.out_kind, bus.out_inum, bus.out_pc, bus.out_inst, bus.out_reg, bus.out_reg_data,
             bus.out_mem_addr, bus.out_mem_data};
      checks++;
      if (expq.size() == 0) begin
        errors++;
        $display("FAIL unexpected entry: got %h expected none", act);
      end else begin
        exq = expq.pop_front();
        if (act !== exq) begin
          errors++;
          $display("FAIL entry inum %0d: got %h expected %h", exq.inum, act, exq);
        end
      end
    end
  task automatic drive(input logic [15:0] pc, inst, input logic rw, input logic [2:0] rg, input logic [15:0] rd,
                       input logic mr, mw, input logic [15:0] ma, md, input logic hl,
                       input logic enq, input logic [2:0] k, input logic [31:0] n);
    bus.cmt_valid = 1'b1;
    bus.cmt_pc = pc;
    bus.cmt_inst = inst;
    bus.cmt_reg_wr = rw;
    bus.cmt_reg = rg;
    bus.cmt_reg_data = rd;
    bus.cmt_mem_rd = mr;
    bus.cmt_mem_wr = mw;
    bus.cmt_mem_addr = ma;
    bus.cmt_mem_data = md;
    bus.cmt_halt = hl;
    if (enq) expq.push_back('{k, n, pc, inst, rg, rd, ma, md});
  endtask
  task automatic commit(input logic [15:0] pc, inst, input logic rw, input logic [2:0] rg, input logic [15:0] rd,
                        input logic mr, mw, input logic [15:0] ma, md, input logic hl,
                        input logic enq, input logic [2:0] k, input logic [31:0] n);
    drive(pc, inst, rw, rg, rd, mr, mw, ma, md, hl, enq, k, n);
    @(posedge clk);
    #1 bus.cmt_valid = 1'b0;
  endtask
  task automatic reset_dut(input logic rdy);
    rst = 1'b1;
    bus.out_ready = rdy;
    expq.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_cycle", cycle_count, 0);
    chk("rst_inst", inst_count, 0);
    chk("rst_drop", drop_count, 0);
    chk("rst_flags", {overflow, halted, done}, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    bus.out_ready = 1'b0;
  endtask
  task automatic drain();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 40 && expq.size() != 0; i++) @(posedge clk);
    #1 bus.out_ready = 1'b0;
    chk("drain", expq.size(), 0);
    @(negedge clk);
    chk("drained_valid", bus.out_valid, 0);
  endtask
  task automatic wait_done();
    for (int i = 0; i < 10 && !done; i++) @(negedge clk);
    chk("done", done, 1);
  endtask
  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
  initial begin
    bus.cmt_valid = 0; bus.cmt_pc = 0; bus.cmt_inst = 0; bus.cmt_reg_wr = 0; bus.cmt_reg = 0;
    bus.cmt_reg_data = 0; bus.cmt_mem_rd = 0; bus.cmt_mem_wr = 0; bus.cmt_mem_addr = 0;
    bus.cmt_mem_data = 0; bus.cmt_halt = 0; bus.out_ready = 0;
    reset_dut(1'b0);
    drive(16'h0002, 16'h1234, 1, 3'd3, 16'h00AA, 0, 0, 16'h0000, 16'h0000, 0, 1, 3'd1, 0);
    @(negedge clk) chk("t1_valid_before", bus.out_valid, 0);
    @(posedge clk) #1 bus.cmt_valid = 1'b0;
    @(negedge clk);
    chk("t1_valid_after", bus.out_valid, 1);
    chk("t1_kind", bus.out_kind, 1);
    chk("t1_inum", bus.out_inum, 0);
    commit(16'h0004, 16'h2222, 1, 3'd1, 16'h0BB0, 0, 1, 16'h0010, 16'h0CC0, 0, 1, 3'd4, 1);
    commit(16'h0006, 16'h3333, 1, 3'd2, 16'h0D00, 1, 0, 16'h0020, 16'h0000, 0, 1, 3'd2, 2);
    commit(16'h0008, 16'h4444, 0, 3'd0, 16'h0000, 0, 1, 16'h0030, 16'h0EEE, 0, 1, 3'd3, 3);
    commit(16'h000A, 16'h5555, 1, 3'd4, 16'h0101, 0, 0, 16'h0000, 16'h0000, 0, 0, 3'd1, 4);
    commit(16'h000C, 16'h6666, 1, 3'd5, 16'h0202, 0, 0, 16'h0000, 16'h0000, 0, 0, 3'd1, 5);
    @(negedge clk);
    chk("t3_drop", drop_count, 2);
    chk("t3_overflow", overflow, 1);
    chk("t3_inst", inst_count, 6);
    chk("t3_head_stable", bus.out_inum, 0);
    bus.out_ready = 1'b1;
    commit(16'h000E, 16'h7777, 1, 3'd6, 16'h0303, 0, 0, 16'h0000, 16'h0000, 0, 1, 3'd1, 6);
    bus.out_ready = 1'b0;
    @(negedge clk);
    chk("t4_drop", drop_count, 2);
    chk("t4_head", bus.out_inum, 1);
    commit(16'h0010, 16'h8888, 1, 3'd7, 16'h0404, 0, 0, 16'h0000, 16'h0000, 0, 0, 3'd1, 7);
    @(negedge clk) chk("t4_still_full", drop_count, 3);
    drain();
    commit(16'h0020, 16'h0000, 0, 3'd0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 3'd0, 8);
    @(negedge clk) chk("t5_nop_filtered", bus.out_valid, 0);
    commit(16'h0022, 16'h9999, 1, 3'd2, 16'h0505, 0, 0, 16'h0000, 16'h0000, 0, 1, 3'd1, 9);
    @(negedge clk);
    chk("t5_inst", inst_count, 10);
    chk("t5_inum", bus.out_inum, 9);
    drain();
    commit(16'h0030, 16'hA000, 1, 3'd1, 16'h1111, 0, 0, 16'h0000, 16'h0000, 0, 1, 3'd1, 10);
    commit(16'h0032, 16'hA001, 1, 3'd2, 16'h2222, 0, 0, 16'h0000, 16'h0000, 0, 1, 3'd1, 11);
    commit(16'h0034, 16'hA002, 1, 3'd3, 16'h3333, 0, 0, 16'h0000, 16'h0000, 0, 1, 3'd1, 12);
    commit(16'h0036, 16'hA003, 1, 3'd4, 16'h4444, 0, 0, 16'h0000, 16'h0000, 0, 0, 3'd1, 13);
    commit(16'h0038, 16'hF000, 0, 3'd0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 1, 1, 3'd5, 14);
    commit(16'h003A, 16'hA004, 1, 3'd5, 16'h5555, 0, 0, 16'h0000, 16'h0000, 0, 0, 3'd1, 15);
    @(negedge clk);
    chk("ow_drop", drop_count, 4);
    chk("ow_halted", halted, 1);
    chk("ow_inst", inst_count, 15);
    drain();
    wait_done();
    reset_dut(1'b0);
    commit(16'h0040, 16'hB000, 1, 3'd1, 16'h0AAA, 0, 0, 16'h0000, 16'h0000, 0, 1, 3'd1, 0);
    commit(16'h0042, 16'hB001, 1, 3'd2, 16'h0BBB, 0, 0, 16'h0000, 16'h0000, 0, 1, 3'd1, 1);
    repeat (17) @(posedge clk);
    #1;
    commit(16'h0044, 16'hF000, 0, 3'd0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 1, 1, 3'd5, 2);
    @(negedge clk);
    chk("t6_halted", halted, 1);
    chk("t6_cycle", cycle_count, 20);
    chk("t6_inst", inst_count, 3);
    commit(16'h0046, 16'hB002, 1, 3'd3, 16'h0CCC, 0, 0, 16'h0000, 16'h0000, 0, 0, 3'd1, 3);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("t6_cycle_frozen", cycle_count, 20);
    chk("t6_inst_frozen", inst_count, 3);
    chk("t6_not_done", done, 0);
    drain();
    wait_done();
    commit(16'h0050, 16'hC000, 1, 3'd1, 16'h0001, 0, 0, 16'h0000, 16'h0000, 0, 0, 3'd1, 0);
    reset_dut(1'b1);
    commit(16'h0052, 16'hC001, 1, 3'd2, 16'h0002, 0, 0, 16'h0000, 16'h0000, 0, 0, 3'd1, 0);
    commit(16'h0054, 16'hC002, 1, 3'd3, 16'h0003, 0, 0, 16'h0000, 16'h0000, 0, 0, 3'd1, 1);
    reset_dut(1'b1);
    chk("sb_empty", expq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
